systolic_tile_engine: RTL

SYSTOLIC_TILE_ENGINE -- requirements
Module: systolic_tile_engine

---
 rtl/systolic_tile_engine.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/systolic_tile_engine.sv
// Output-stationary N x N systolic tile: streams K operand beats through skewed edges,
// accumulates C = A x B in place, then presents C one row at a time.
module systolic_tile_engine #(
  parameter int N     = 4,
  parameter int W     = 16,
  parameter int K_MAX = 256,
  parameter int ACC_W = 2*W + $clog2(K_MAX)
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           start,
  input  logic [$clog2(K_MAX+1)-1:0]     k_len,
  input  logic                           accumulate,
  output logic                           busy,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [N-1:0][W-1:0]            a_col,
  input  logic [N-1:0][W-1:0]            b_row,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [N-1:0][ACC_W-1:0]        out_row,
  output logic [$clog2(N)-1:0]           out_idx,
  output logic                           done
);

  localparam int KW = $clog2(K_MAX+1);
  localparam int IW = $clog2(N);
  localparam int FW = $clog2(2*N);

  // Both handshakes transfer on the rising edge where valid && ready; in_ready is
  // high only in LOAD and out_valid only in OUTPUT, neither depends on its partner.
  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, OUTPUT} state_t;

  state_t                          r_state, w_next;
  logic [KW-1:0]                   r_k_len, r_beats;
  logic [FW-1:0]                   r_flush;
  logic [IW-1:0]                   r_idx;
  logic                            r_done;
  logic                            w_fire, w_out_fire, w_clear, w_start;

  logic [W-1:0]                    w_a_in   [N];
  logic [W-1:0]                    w_b_in   [N];
  logic [W-1:0]                    w_a_skew [N];
  logic [W-1:0]                    w_b_skew [N];
  logic [W-1:0]                    w_a_left [N][N];
  logic [W-1:0]                    w_b_top  [N][N];
  logic signed [2*W-1:0]           w_prod   [N][N];
  logic signed [ACC_W-1:0]         w_ext    [N][N];
  logic [W-1:0]                    r_a_pass [N][N-1];
  logic [W-1:0]                    r_b_pass [N-1][N];
  logic [N-1:0][N-1:0][ACC_W-1:0]  r_acc;

  assign busy       = (r_state != IDLE);
  assign in_ready   = (r_state == LOAD);
  assign out_valid  = (r_state == OUTPUT);
  assign out_idx    = r_idx;
  assign out_row    = r_acc[r_idx];
  assign done       = r_done;
  assign w_fire     = in_valid && in_ready;
  assign w_out_fire = out_valid && out_ready;
  assign w_start    = (r_state == IDLE) && start;
  assign w_clear    = w_start && !accumulate;

  // Skew lines: bubbles carry zeros so idle cycles add nothing to any accumulator.
  for (genvar i = 0; i < N; i++) begin : g_skew
    assign w_a_in[i] = w_fire ? a_col[i] : '0;
    assign w_b_in[i] = w_fire ? b_row[i] : '0;
    if (i == 0) begin : g_direct
      assign w_a_skew[i] = w_a_in[i];
      assign w_b_skew[i] = w_b_in[i];
    end else begin : g_delay
      logic [i-1:0][W-1:0] r_a_sh, r_b_sh;
      always_ff @(posedge clock) begin
        if (reset) begin
          r_a_sh <= '0;
          r_b_sh <= '0;
        end else begin
          r_a_sh[0] <= w_a_in[i];
          r_b_sh[0] <= w_b_in[i];
          for (int d = 1; d < i; d++) begin
            r_a_sh[d] <= r_a_sh[d-1];
            r_b_sh[d] <= r_b_sh[d-1];
          end
        end
      end
      assign w_a_skew[i] = r_a_sh[i-1];
      assign w_b_skew[i] = r_b_sh[i-1];
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      if (j == 0) begin : g_a_edge
        assign w_a_left[i][j] = w_a_skew[i];
      end else begin : g_a_inner
        assign w_a_left[i][j] = r_a_pass[i][j-1];
      end
      if (i == 0) begin : g_b_edge
        assign w_b_top[i][j] = w_b_skew[j];
      end else begin : g_b_inner
        assign w_b_top[i][j] = r_b_pass[i-1][j];
      end
      assign w_prod[i][j] = (2*W)'($signed(w_a_left[i][j])) * (2*W)'($signed(w_b_top[i][j]));
      assign w_ext[i][j]  = ACC_W'(w_prod[i][j]);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_acc <= '0;
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N-1; j++) begin
          r_a_pass[i][j] <= '0;
          r_b_pass[j][i] <= '0;
        end
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N-1; j++) begin
          r_a_pass[i][j] <= w_a_left[i][j];
          r_b_pass[j][i] <= w_b_top[j][i];
        end
        for (int j = 0; j < N; j++) begin
          r_acc[i][j] <= w_clear ? '0 : r_acc[i][j] + w_ext[i][j];
        end
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = (k_len == '0) ? FLUSH : LOAD;
      LOAD:    if (w_fire && (r_beats == r_k_len - KW'(1))) w_next = FLUSH;
      // 2N-1 cycles lets the last beat reach PE[N-1][N-1].
      FLUSH:   if (r_flush == FW'(2*N-2)) w_next = OUTPUT;
      OUTPUT:  if (w_out_fire && (r_idx == IW'(N-1))) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_k_len <= '0;
      r_beats <= '0;
      r_flush <= '0;
      r_idx   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= w_out_fire && (r_idx == IW'(N-1));
      if (w_start) begin
        r_k_len <= k_len;
        r_beats <= '0;
        r_flush <= '0;
        r_idx   <= '0;
      end
      if (w_fire) r_beats <= r_beats + KW'(1);
      if (r_state == FLUSH) r_flush <= r_flush + FW'(1);
      if (w_out_fire) r_idx <= (r_idx == IW'(N-1)) ? '0 : r_idx + IW'(1);
    end
  end

endmodule
